uart_tx_engine: RTL
===================

# uart_tx_engine

- Transmit-side controller of the UART.
- Accepts a parallel byte on a load strobe and serializes it onto `tx` as a framed asynchronous character: start bit, data bits (LSB first), optional parity bit and one stop bit.
- Sequences an internal bit-time counter, selects its terminal count from a baud-rate code, and reports readiness back to the TSI/processor side.

## Interface

Parameters: none. Baud table and frame constants live in the shared package.

- `clk`  in  1  100 MHz system clock
- `reset`  in  1  asynchronous, active-high
- `load`  in  1  one-cycle strobe; request to transmit `out_port`
- `out_port`  in  8  data byte to send
- `baud_sel`  in  4  baud-rate code, sampled on accepted load
- `eight`  in  1  1 = 8 data bits, 0 = 7 data bits (`out_port[6:0]`)
- `pen`  in  1  parity enable
- `ohel`  in  1  parity sense: 0 = even, 1 = odd
- `tx`  out  1  serial line; idle high
- `tx_rdy`  out  1  high when able to accept a load
- `tx_done`  out  1  one-cycle pulse when a frame's stop bit completes

## Operation

- Reset values:
  - `tx` = 1, `tx_rdy` = 1, `tx_done` = 0
  - state IDLE; bit timer 0; shift register 0
- Load acceptance:
  - A load is accepted only when `load` = 1 and `tx_rdy` = 1.
  - Loads while busy are ignored; no queueing.
  - On acceptance, latch `out_port`, `eight`, `pen`, `ohel` and the terminal count N looked up from `baud_sel`.
  - Input changes after acceptance do not affect the frame in flight.
- Baud table (terminal counts at 100 MHz):
  - 0:333332, 1:166666, 2:83332, 3:41666, 4:20832, 5:10416, 6:5207, 7:2603, 8:1735, 9:867, 10:433, 11:216, 12:108.
  - Codes 13–15 map to 867.
- Bit timer:
  - 19-bit counter, cleared while `doit` = 0.
  - Increments while `doit` = 1; asserts `btu` when count == N, then reloads 0.
  - One bit time = N+1 clocks.
- FSM states:
  - IDLE –accepted load→ START
  - START –btu→ DATA
  - DATA –btu on last data bit→ PARITY if latched `pen`, else STOP
  - PARITY –btu→ STOP
  - STOP –btu→ IDLE
- `doit` is 1 in every state except IDLE.
- Data bit count: 8 if latched `eight`, else 7. Shift LSB first; the data-bit index counter wraps to 0 at frame end.
- Parity bit = XOR of the transmitted data bits, inverted when `ohel` = 1.
- Frame length: 9 to 11 bits.

## Timing

- Load sampled at edge k:
  - `tx_rdy` = 0 from k+1.
  - `tx` = 0 (start bit) from k+1.
- Every bit occupies exactly N+1 cycles on `tx`.
- Stop bit (`tx` = 1) ends at edge e; at e, `tx_rdy` = 1 and `tx_done` = 1 for one cycle.
- Load asserted in cycle e is accepted: back-to-back frames with no idle gap.
- Total busy time = frame_bits × (N+1) cycles.
- Reset mid-frame: outputs return to reset values immediately (asynchronous); the partial frame is abandoned.
- `baud_sel` change while busy: no effect until the next accepted load.

## Configuration

- `UART_TX_PARITY_EN` defined: parity logic and the PARITY state are present; behaviour as above.
- Not defined:
  - `pen` and `ohel` remain as ports but are ignored.
  - PARITY state and parity generator are absent.
  - Frames are always start + 7/8 data + stop.

## Structure

- Shared package `uart_pkg` holds:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP)
  - 19-bit baud terminal-count table and lookup function
  - Constants: `BAUD_W` = 19, `DATA_MAX` = 8
- One sub-module, `uart_bit_timer`: inputs `clk`, `reset`, `doit`, `term[18:0]`; output `btu`. It has the counter semantics given under Operation.

## Test plan

- Reset → `tx` = 1, `tx_rdy` = 1, `tx_done` = 0. Load 0x55, `baud_sel` = 12, `eight` = 1, `pen` = 0 → `tx` sequence 0,1,0,1,0,1,0,1,0,1, each exactly 109 cycles; `tx_rdy` low for 1090 cycles; one `tx_done` pulse.
- With macro defined, load 0xA3, `eight` = 1, `pen` = 1, `ohel` = 0 → parity bit 0, 11-bit frame. Repeat with `ohel` = 1 → parity bit 1.
- `eight` = 0, load 0xFF → 7 ones after start, then stop; bit 7 never transmitted; frame of 9 bits.
- Second load while busy → ignored, frame unchanged. Load in the `tx_done` cycle → next start bit begins the following cycle, no idle gap.
- Change `baud_sel` 12→11 mid-frame → current bits stay 109 cycles; next frame 217 cycles per bit. `baud_sel` = 14 → 868 cycles per bit.
- Assert `reset` during DATA → `tx` = 1 and `tx_rdy` = 1 immediately; after release, a fresh load sends a full correct frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   tx_state_e      : transmit FSM states
//   BAUD_W          : width of the bit-time counter / terminal count
//   DATA_MAX        : maximum number of data bits per character
//   baud_term()     : baud code -> terminal count N (bit time = N+1 clocks at 100 MHz)
//   data_parity()   : XOR of the 7 or 8 data bits that will be transmitted
package uart_pkg;

  localparam int BAUD_W   = 19;
  localparam int DATA_MAX = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  function automatic logic [BAUD_W-1:0] baud_term(input logic [3:0] code);
    logic [BAUD_W-1:0] n;
    case (code)
      4'd0:    n = 19'd333332;
      4'd1:    n = 19'd166666;
      4'd2:    n = 19'd83332;
      4'd3:    n = 19'd41666;
      4'd4:    n = 19'd20832;
      4'd5:    n = 19'd10416;
      4'd6:    n = 19'd5207;
      4'd7:    n = 19'd2603;
      4'd8:    n = 19'd1735;
      4'd9:    n = 19'd867;
      4'd10:   n = 19'd433;
      4'd11:   n = 19'd216;
      4'd12:   n = 19'd108;
      default: n = 19'd867;  // unused codes fall back to the 9 (867) rate
    endcase
    return n;
  endfunction

  function automatic logic data_parity(input logic [7:0] d, input logic eight);
    return ^(eight ? d : {1'b0, d[6:0]});
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-time counter for the UART transmitter.
//   clk, reset : clock, asynchronous active-high reset
//   doit       : count enable; counter held at 0 while low
//   term       : terminal count N
//   btu        : high for the cycle in which count == N (one bit time = N+1 clocks)
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              doit,
  input  logic [BAUD_W-1:0] term,
  output logic              btu
);

  logic [BAUD_W-1:0] count_q, count_d;

  assign btu = doit && (count_q == term);

  always_comb begin
    count_d = count_q + BAUD_W'(1);
    if (!doit || btu) count_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: accepts a byte on load and sends start, 7/8 data bits
// (LSB first), optional parity and one stop bit on tx.
//   clk, reset       : 100 MHz clock, asynchronous active-high reset
//   load, out_port   : one-cycle transmit request and data byte
//   baud_sel         : baud code, sampled when a load is accepted
//   eight, pen, ohel : 8/7 data bits, parity enable, odd parity select
//   tx               : serial output, idle high
//   tx_rdy           : able to accept a load
//   tx_done          : one-cycle pulse after the stop bit completes
// Build option: define UART_TX_PARITY_EN to include the parity bit; without it
// pen and ohel are ignored and frames are start + data + stop.
//
// state  | meaning
// IDLE   | line high, waiting for load
// START  | sending start bit (0)
// DATA   | sending data bits LSB first
// PARITY | sending parity bit (parity build only)
// STOP   | sending stop bit (1); tx_done follows
module uart_tx_engine
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] out_port,
  input  logic [3:0] baud_sel,
  input  logic       eight,
  input  logic       pen,
  input  logic       ohel,
  output logic       tx,
  output logic       tx_rdy,
  output logic       tx_done
);

  tx_state_e         state_q, state_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic              eight_q, eight_d;
  logic [BAUD_W-1:0] term_q, term_d;
  logic              tx_done_q, tx_done_d;
  logic              doit, btu, last_bit;

`ifdef UART_TX_PARITY_EN
  logic pen_q, pen_d;
  logic parity_q, parity_d;
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = pen ^ ohel;
`endif

  assign doit     = (state_q != IDLE);
  assign tx_rdy   = (state_q == IDLE);
  assign tx_done  = tx_done_q;
  assign last_bit = (bit_idx_q == (eight_q ? 3'(DATA_MAX - 1) : 3'(DATA_MAX - 2)));

  uart_bit_timer u_bit_timer (
    .clk   (clk),
    .reset (reset),
    .doit  (doit),
    .term  (term_q),
    .btu   (btu)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    eight_d   = eight_q;
    term_d    = term_q;
    tx_done_d = 1'b0;
    tx        = 1'b1;
`ifdef UART_TX_PARITY_EN
    pen_d     = pen_q;
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d   = START;
          shift_d   = out_port;
          eight_d   = eight;
          term_d    = baud_term(baud_sel);
          bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
          pen_d     = pen;
          parity_d  = data_parity(out_port, eight) ^ ohel;
`endif
        end
      end
      START: begin
        tx = 1'b0;
        if (btu) state_d = DATA;
      end
      DATA: begin
        tx = shift_q[0];
        if (btu) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (last_bit) begin
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = pen_q ? PARITY : STOP;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx = parity_q;
        if (btu) state_d = STOP;
      end
`endif
      STOP: begin
        if (btu) begin
          state_d   = IDLE;
          tx_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      eight_q   <= 1'b0;
      term_q    <= '0;
      tx_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      pen_q     <= 1'b0;
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      eight_q   <= eight_d;
      term_q    <= term_d;
      tx_done_q <= tx_done_d;
`ifdef UART_TX_PARITY_EN
      pen_q     <= pen_d;
      parity_q  <= parity_d;
`endif
    end
  end

endmodule
